// File: rtl/shift_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready word input and a shift_en bit strobe.
// Optional even-parity trailer bit is enabled by defining SHIFT_TX_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a word; load_ready high, line held at 0
// SHIFT | data bits on the line, one consumed per shift_en strobe
// PAR   | parity bit on the line (only with SHIFT_TX_PARITY_EN)
module shift_tx #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             direction,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef SHIFT_TX_PARITY_EN
        PAR   = 2'd2,
`endif
        SHIFT = 2'd1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             dir_q;
    logic             done_q;
    logic             accept;
    logic             consume;
    logic             done_nxt;
`ifdef SHIFT_TX_PARITY_EN
    logic             par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        frame      = 1'b0;
        serial_out = 1'b0;
        accept     = 1'b0;
        consume    = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                frame      = 1'b1;
                serial_out = dir_q ? shreg[WIDTH-1] : shreg[0];
                if (shift_en) begin
                    consume = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SHIFT_TX_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
`endif
                    end
                end
            end
`ifdef SHIFT_TX_PARITY_EN
            PAR: begin
                frame      = 1'b1;
                serial_out = par_q;
                if (shift_en) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Direction is latched at accept so a mid-frame change cannot scramble the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (accept) begin
                shreg   <= load_data;
                bit_cnt <= '0;
                dir_q   <= direction;
            end else if (consume) begin
                shreg   <= dir_q ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SHIFT_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^load_data;
        end
    end
`endif

    assign done = done_q;

endmodule

// File: tb/tb_shift_tx.sv
// Scoreboard bench for shift_tx: the driver queues expected bits and words, a negedge
// monitor compares line bits and rebuilds each word as a receiver would.
module tb_shift_tx;

    localparam int W = 10;
`ifdef SHIFT_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         direction = 1'b0;
    logic         shift_en = 1'b0;
    logic         serial_out;
    logic         frame;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic         bit_q[$];
    logic [W-1:0] word_q[$];

    always #5 clk = ~clk;

    shift_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .direction  (direction),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .frame      (frame),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: consumes one expected bit per strobed frame cycle, checks each done.
    int           cyc = 0;
    int           consumed = 0;
    int           frame_cyc = 0;
    int           last_cons = 0;
    logic         dir_m = 1'b0;
    logic [W-1:0] rx = '0;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (frame) begin
                chk("load_ready_busy", {31'd0, load_ready}, 32'd0);
                frame_cyc++;
            end else begin
                chk("idle_serial", {31'd0, serial_out}, 32'd0);
            end
            if (frame && shift_en) begin
                if (bit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %0b expected none", serial_out);
                end else begin
                    chk("serial_bit", {31'd0, serial_out}, {31'd0, bit_q.pop_front()});
                end
                if (consumed < W) rx = dir_m ? {rx[W-2:0], serial_out} : {serial_out, rx[W-1:1]};
                consumed++;
                last_cons = cyc;
            end
            if (done) begin
                chk("done_idle", {30'd0, frame, load_ready}, 32'd1);
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    chk("rx_word", {22'd0, rx}, {22'd0, word_q.pop_front()});
                end
                chk("bits_per_frame", consumed, FL);
                chk("done_after_last_bit", cyc - last_cons, 1);
                chk("frame_continuous", frame_cyc, cyc - 1);
            end
            if (load_valid && load_ready) begin
                cyc       = 0;
                consumed  = 0;
                frame_cyc = 0;
                last_cons = 0;
                dir_m     = direction;
                rx        = '0;
            end
        end
    end

    task automatic push_model(input logic [W-1:0] w, input logic d);
        for (int i = 0; i < W; i++) bit_q.push_back(d ? w[W-1-i] : w[i]);
`ifdef SHIFT_TX_PARITY_EN
        bit_q.push_back(^w);
`endif
        word_q.push_back(w);
    endtask

    task automatic push_seq(input logic [W-1:0] seq, input logic [W-1:0] w, input logic par);
        for (int i = 0; i < W; i++) bit_q.push_back(seq[W-1-i]);
`ifdef SHIFT_TX_PARITY_EN
        bit_q.push_back(par);
`else
        if (par === 1'bx) bit_q.push_back(1'b0);
`endif
        word_q.push_back(w);
    endtask

    // mode 0: shift_en high except frame cycles s0..s1; mode 1: random shift_en.
    task automatic send(input logic [W-1:0] w, input logic d, input int mode,
                        input int s0, input int s1, input bit b2b);
        int t;
        bit got_done;
        load_data  = w;
        direction  = d;
        load_valid = 1'b1;
        if (b2b) chk("b2b_ready", {31'd0, load_ready}, 32'd1);
        t = 0;
        while (!load_ready && t < 100) begin
            tick();
            t++;
        end
        tick();
        load_valid = 1'b0;
        load_data  = ~w;
        direction  = ~d;
        chk("frame_after_accept", {31'd0, frame}, 32'd1);
        got_done = 1'b0;
        for (int c = 1; c < 300; c++) begin
            if (mode == 1) shift_en = ($urandom_range(0, 3) != 0);
            else           shift_en = !(c >= s0 && c <= s1);
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        shift_en = 1'b1;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic         d;
        repeat (3) tick();
        rst      = 1'b0;
        shift_en = 1'b1;
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_serial", {31'd0, serial_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", {31'd0, load_ready}, 32'd1);
            chk("idle_frame", {31'd0, frame}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        push_seq(10'b1010100101, 10'h2A5, 1'b1);
        send(10'h2A5, 1'b1, 0, 0, -1, 1'b0);
        push_seq(10'b1010010101, 10'h2A5, 1'b1);
        send(10'h2A5, 1'b0, 0, 0, -1, 1'b1);
        push_seq(10'b1010100101, 10'h2A5, 1'b1);
        send(10'h2A5, 1'b1, 0, 3, 6, 1'b1);

        for (int k = 0; k < 8; k++) begin
            w = W'($urandom_range(0, (1 << W) - 1));
            d = 1'($urandom_range(0, 1));
            push_model(w, d);
            send(w, d, 1, 0, -1, 1'b1);
        end

        // Reset partway through a frame: bits 0..4 go out, bit 5 is cut off by reset.
        tick();
        load_data  = 10'h2A5;
        direction  = 1'b1;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        for (int i = 0; i < 5; i++) bit_q.push_back(i[0] ? 1'b0 : 1'b1);
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_frame", {31'd0, frame}, 32'd0);
        chk("midrst_serial", {31'd0, serial_out}, 32'd0);
        chk("midrst_ready", {31'd0, load_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_no_done", {31'd0, done}, 32'd0);
        end

        chk("bits_drained", bit_q.size(), 0);
        chk("words_drained", word_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
